mem_bist_sequencer: RTL and testbench

- Initiator-side controller for the team's single-port synchronous RAM (registered read address, write on posedge when `we`).
- On `start`, fills the whole RAM with a seeded pattern, reads every location back and compares it to the expected value.
- Reports pass/fail, the error count and the first failing address.
- Sits between a host/test controller and the RAM instance. It owns the RAM's `data`/`addr`/`we` pins and observes `q`.

---
 rtl/mem_bist_sequencer_if.sv | 27 ++
 rtl/mem_bist_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mem_bist_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_sequencer_if.sv
// RAM-side bus of the BIST sequencer: write data, address and write enable
// driven by the controller, read data returned by the single-port RAM.
interface mem_bist_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;

  // Controller side: owns data/addr/we, observes q.
  modport master (
    output mem_data,
    output mem_addr,
    output mem_we,
    input  mem_q
  );

  // RAM side: consumes data/addr/we, returns q.
  modport slave (
    input  mem_data,
    input  mem_addr,
    input  mem_we,
    output mem_q
  );
endinterface

// File: rtl/mem_bist_sequencer.sv
// Memory BIST sequencer: on start, writes seed^addr to every location of a
// single-port synchronous RAM, reads everything back, and reports the number
// of mismatches and the first failing address.
module mem_bist_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_seed,
  mem_bist_sequencer_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_WIDTH:0]   o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Highest address exercised; both WRITE and READ stop after issuing it.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Expected pattern: seed XOR address, address zero-extended or truncated
  // to the data width.
  function automatic logic [DATA_WIDTH-1:0] f_pattern(
    input logic [DATA_WIDTH-1:0] seed,
    input logic [ADDR_WIDTH-1:0] addr
  );
    return seed ^ DATA_WIDTH'(addr);
  endfunction

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic                  r_cmp_valid;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;

  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_cmp_exp;
  logic                  w_mismatch;
  logic [ADDR_WIDTH:0]   w_err_count_next;
  logic [ADDR_WIDTH-1:0] w_first_err_next;

  assign w_last    = (r_cnt == LAST_ADDR);
  assign w_cnt_inc = r_cnt + ADDR_WIDTH'(1);

  // The compare stage lags the issued read address by one cycle: q for the
  // address issued in cycle t is on the bus during cycle t+1.
  assign w_cmp_exp        = f_pattern(r_seed, r_cmp_addr);
  assign w_mismatch       = r_cmp_valid && (bus.mem_q != w_cmp_exp);
  assign w_err_count_next = r_err_count + (ADDR_WIDTH + 1)'(w_mismatch);
  assign w_first_err_next = (w_mismatch && (r_err_count == '0)) ? r_cmp_addr
                                                                : r_first_err_addr;

  // Sequencer FSM with all RAM-side and status outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_seed           <= '0;
      r_cnt            <= '0;
      r_cmp_addr       <= '0;
      r_cmp_valid      <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_data           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // New run: latch the seed, drop the previous results and put
            // the first write (address 0) on the bus right away.
            r_state          <= S_WRITE;
            r_seed           <= i_seed;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_cnt            <= '0;
            r_cmp_valid      <= 1'b0;
            r_we             <= 1'b1;
            r_addr           <= '0;
            r_data           <= f_pattern(i_seed, '0);
            r_busy           <= 1'b1;
          end
        end

        S_WRITE: begin
          if (w_last) begin
            // First read of address 0 follows the last write directly.
            r_state <= S_READ;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_addr <= w_cnt_inc;
            r_data <= f_pattern(r_seed, w_cnt_inc);
          end
        end

        S_READ: begin
          // Retire the compare of the previous read, queue the current one.
          r_err_count      <= w_err_count_next;
          r_first_err_addr <= w_first_err_next;
          r_cmp_valid      <= 1'b1;
          r_cmp_addr       <= r_cnt;
          if (w_last) begin
            r_state <= S_DRAIN;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_addr <= w_cnt_inc;
          end
        end

        S_DRAIN: begin
          // Final compare (last address); pass must include its outcome.
          r_err_count      <= w_err_count_next;
          r_first_err_addr <= w_first_err_next;
          r_pass           <= (w_err_count_next == '0);
          r_cmp_valid      <= 1'b0;
          r_done           <= 1'b1;
          r_busy           <= 1'b0;
          r_state          <= S_DONE;
        end

        S_DONE: begin
          // Always pass through IDLE before another run can start.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we   = r_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_data = r_data;

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Self-checking bench for mem_bist_sequencer: a behavioural single-port RAM
// with injectable read faults, a run monitor, and an address-level model of
// which locations should mismatch.
module tb_mem_bist_sequencer;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int D  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  mem_bist_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_bist_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_seed          (seed),
    .bus             (bus),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_err_count     (err_count),
    .o_first_err_addr(first_err_addr)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- RAM model with fault injection ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] q_late;
  int            cyc = 0;
  int            t0  = -100000;
  bit            flip_en = 0;
  logic [AW-1:0] flip_addr = '0;
  logic [DW-1:0] flip_mask = '0;
  logic [DW-1:0] stuck0_mask = '0;
  bit            late_mode = 0;
  bit            tr_en = 0;
  int            tr_cycle = 0;

  wire [DW-1:0] q_now  = ram[ram_ra];
  wire [DW-1:0] q_sel  = late_mode ? q_late : q_now;
  wire [DW-1:0] q_flip = (flip_en && ram_ra == flip_addr) ? flip_mask : '0;
  wire [DW-1:0] q_tr   = (tr_en && (cyc - t0) == tr_cycle) ? 8'h01 : 8'h00;
  assign bus.mem_q = (q_sel ^ q_flip ^ q_tr) & ~stuck0_mask;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    ram_ra <= bus.mem_addr;
    q_late <= q_now;
    cyc    <= cyc + 1;
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
  end

  // ---------------- Reference model ----------------
  // Address a is written with seed^a; what is read back is that value, or
  // (late q) the previously read location's value, where the location before
  // address 0 is the last one written; then the configured faults apply.
  // Address a is compared at cycle D+1+a after the start edge.
  int m_errs;
  int m_first;
  function automatic void model(input logic [DW-1:0] s);
    logic [DW-1:0] expv;
    logic [DW-1:0] obs;
    m_errs  = 0;
    m_first = -1;
    for (int a = 0; a < D; a++) begin
      expv = s ^ DW'(a);
      if (late_mode) obs = (a == 0) ? (s ^ DW'(D - 1)) : (s ^ DW'(a - 1));
      else           obs = expv;
      if (flip_en && a == int'(flip_addr)) obs = obs ^ flip_mask;
      if (tr_en && a == tr_cycle - (D + 1)) obs = obs ^ 8'h01;
      obs = obs & ~stuck0_mask;
      if (obs != expv) begin
        m_errs++;
        if (m_first < 0) m_first = a;
      end
    end
    if (m_first < 0) m_first = 0;
  endfunction

  task automatic clear_faults();
    flip_en = 0; flip_mask = '0; stuck0_mask = '0; late_mode = 0; tr_en = 0;
  endtask

  // ---------------- Run monitor ----------------
  int   r_done_cyc, r_done_cnt, r_wr_cnt, r_wr_bad, r_rd_bad, r_busy_bad;
  logic r_pass;
  logic [AW:0]   r_err;
  logic [AW-1:0] r_first;

  task automatic run_bist(input logic [DW-1:0] s, input int pulse_at);
    int n;
    r_done_cyc = -1; r_done_cnt = 0; r_wr_cnt = 0;
    r_wr_bad = 0; r_rd_bad = 0; r_busy_bad = 0;
    r_pass = 1'bx; r_err = 'x; r_first = 'x;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    seed  = DW'($urandom);
    n = 0;
    while (n < 2 * D + 3) begin
      @(negedge clk);
      n = cyc - t0;
      if (pulse_at >= 0 && n == pulse_at + 1) start = 1'b0;
      if (n == pulse_at) start = 1'b1;
      if (n < D) begin
        if (!(bus.mem_we === 1'b1 && bus.mem_addr === AW'(n) &&
              bus.mem_data === (s ^ DW'(n)))) r_wr_bad++;
      end else if (n < 2 * D) begin
        if (!(bus.mem_we === 1'b0 && bus.mem_addr === AW'(n - D) &&
              bus.mem_data === '0)) r_rd_bad++;
      end else begin
        if (!(bus.mem_we === 1'b0 && bus.mem_addr === AW'(D - 1) &&
              bus.mem_data === '0)) r_rd_bad++;
      end
      if (bus.mem_we === 1'b1) r_wr_cnt++;
      if (n <= 2 * D && busy !== 1'b1) r_busy_bad++;
      if (n > 2 * D && busy !== 1'b0) r_busy_bad++;
      if (done === 1'b1) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = n; r_pass = pass; r_err = err_count; r_first = first_err_addr;
        end
      end
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; seed = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_data} !== '0) begin errors++;
      $display("FAIL reset_bus got we=%b addr=%0d data=%0h want 0 0 0", bus.mem_we, bus.mem_addr, bus.mem_data); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got busy=%b done=%b pass=%b want 000", busy, done, pass); end
    checks++; if ({err_count, first_err_addr} !== '0) begin errors++;
      $display("FAIL reset_results got err=%0d first=%0d want 0 0", err_count, first_err_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_clean_run();
    clear_faults();
    run_bist(8'hA5, -1);
    model(8'hA5);
    checks++; if (r_done_cyc !== 2 * D + 1) begin errors++;
      $display("FAIL clean_done_cycle got %0d want %0d", r_done_cyc, 2 * D + 1); end
    checks++; if (r_done_cnt !== 1) begin errors++;
      $display("FAIL clean_done_count got %0d want 1", r_done_cnt); end
    checks++; if (r_wr_cnt !== D) begin errors++;
      $display("FAIL clean_write_count got %0d want %0d", r_wr_cnt, D); end
    checks++; if (ram[3] !== 8'hA6) begin errors++;
      $display("FAIL clean_loc3 got %0h want a6", ram[3]); end
    checks++; if (ram[63] !== 8'h9A) begin errors++;
      $display("FAIL clean_loc63 got %0h want 9a", ram[63]); end
    checks++; if (r_wr_bad !== 0 || r_rd_bad !== 0 || r_busy_bad !== 0) begin errors++;
      $display("FAIL clean_protocol got wr_bad=%0d rd_bad=%0d busy_bad=%0d want 0 0 0", r_wr_bad, r_rd_bad, r_busy_bad); end
    checks++; if (r_pass !== 1'b1 || r_err !== (AW+1)'(m_errs) || r_first !== AW'(m_first)) begin errors++;
      $display("FAIL clean_result got pass=%b err=%0d first=%0d want 1 %0d %0d", r_pass, r_err, r_first, m_errs, m_first); end
    checks++; if (pass !== 1'b1 || err_count !== '0) begin errors++;
      $display("FAIL clean_hold got pass=%b err=%0d want 1 0", pass, err_count); end
    $display("test_clean_run seed=a5 done_cycle=%0d err=%0d", r_done_cyc, r_err);
  endtask

  task automatic test_random_faults();
    logic [DW-1:0] s;
    for (int i = 0; i < 4; i++) begin
      clear_faults();
      s = DW'($urandom);
      if (i > 0) begin
        flip_en   = 1;
        flip_addr = AW'($urandom_range(0, D - 1));
        flip_mask = DW'($urandom_range(1, 255));
      end
      if (i == 3) stuck0_mask = DW'(1 << $urandom_range(0, DW - 1));
      run_bist(s, -1);
      model(s);
      checks++; if (r_err !== (AW+1)'(m_errs) || r_first !== AW'(m_first) ||
                    r_pass !== (m_errs == 0)) begin errors++;
        $display("FAIL random_%0d got err=%0d first=%0d pass=%b want %0d %0d %b",
                 i, r_err, r_first, r_pass, m_errs, m_first, (m_errs == 0)); end
      $display("test_random_faults run=%0d seed=%0h err=%0d first=%0d", i, s, r_err, r_first);
    end
  endtask

  task automatic test_single_fault();
    logic [DW-1:0] s;
    clear_faults();
    s = DW'($urandom);
    flip_en = 1; flip_addr = AW'(5); flip_mask = 8'h01;
    run_bist(s, -1);
    checks++; if (r_err !== 7'd1 || r_first !== 6'd5 || r_pass !== 1'b0) begin errors++;
      $display("FAIL single_fault got err=%0d first=%0d pass=%b want 1 5 0", r_err, r_first, r_pass); end
    $display("test_single_fault seed=%0h err=%0d first=%0d", s, r_err, r_first);
  endtask

  task automatic test_multi_fault();
    clear_faults();
    stuck0_mask = 8'h80;
    run_bist(8'h80, -1);
    model(8'h80);
    checks++; if (r_err !== 7'd64 || r_err !== (AW+1)'(m_errs) || r_first !== 6'd0 || r_pass !== 1'b0) begin errors++;
      $display("FAIL multi_fault got err=%0d first=%0d pass=%b want 64 0 0", r_err, r_first, r_pass); end
    $display("test_multi_fault err=%0d first=%0d", r_err, r_first);
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] s;
    clear_faults();
    s = DW'($urandom);
    flip_en = 1; flip_addr = AW'($urandom_range(0, D - 1)); flip_mask = 8'h10;
    run_bist(s, D + 10);
    checks++; if (r_done_cnt !== 1 || r_done_cyc !== 2 * D + 1) begin errors++;
      $display("FAIL start_ignored got dones=%0d at=%0d want 1 at %0d", r_done_cnt, r_done_cyc, 2 * D + 1); end
    checks++; if (r_err !== 7'd1 || r_first !== flip_addr) begin errors++;
      $display("FAIL start_ignored_result got err=%0d first=%0d want 1 %0d", r_err, r_first, flip_addr); end
    clear_faults();
    run_bist(DW'($urandom), -1);
    checks++; if (r_err !== '0 || r_pass !== 1'b1 || r_first !== '0) begin errors++;
      $display("FAIL rerun_clears got err=%0d pass=%b first=%0d want 0 1 0", r_err, r_pass, r_first); end
    $display("test_start_ignored dones=%0d rerun_err=%0d", r_done_cnt, r_err);
  endtask

  task automatic test_read_timing();
    int k;
    clear_faults();
    k = $urandom_range(0, D - 1);
    tr_en = 1; tr_cycle = D + 1 + k;
    run_bist(8'h00, -1);
    model(8'h00);
    checks++; if (r_rd_bad !== 0) begin errors++;
      $display("FAIL read_addr_timing got bad=%0d want 0", r_rd_bad); end
    checks++; if (r_err !== 7'd1 || r_first !== AW'(k) || r_first !== AW'(m_first)) begin errors++;
      $display("FAIL compare_timing got err=%0d first=%0d want 1 %0d", r_err, r_first, k); end
    clear_faults();
    late_mode = 1;
    run_bist(8'h00, -1);
    model(8'h00);
    checks++; if (r_pass !== 1'b0 || r_err !== (AW+1)'(m_errs) || r_first !== AW'(m_first)) begin errors++;
      $display("FAIL late_q got pass=%b err=%0d first=%0d want 0 %0d %0d", r_pass, r_err, r_first, m_errs, m_first); end
    clear_faults();
    $display("test_read_timing k=%0d late_err=%0d", k, r_err);
  endtask

  task automatic test_back_to_back();
    int n;
    clear_faults();
    @(negedge clk);
    seed = DW'($urandom); start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n = cyc - t0;
    end
    checks++; if (n !== 2 * D + 1) begin errors++;
      $display("FAIL b2b_done got cycle=%0d want %0d", n, 2 * D + 1); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin errors++;
      $display("FAIL b2b_idle_gap got busy=%b we=%b want 0 0", busy, bus.mem_we); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== '0) begin errors++;
      $display("FAIL b2b_restart got busy=%b we=%b addr=%0d want 1 1 0", busy, bus.mem_we, bus.mem_addr); end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
      $display("FAIL b2b_second_run got done=%b pass=%b want 1 1", done, pass); end
    @(negedge clk);
    $display("test_back_to_back second_run_cycles=%0d", n);
  endtask

  task automatic test_reset_mid_write();
    clear_faults();
    @(negedge clk);
    seed = DW'($urandom); start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc; start = 1'b0;
    while (cyc - t0 < 10) @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10) begin errors++;
      $display("FAIL midwrite_pre got we=%b addr=%0d want 1 10", bus.mem_we, bus.mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL midwrite_reset got we=%b busy=%b want 0 0", bus.mem_we, busy); end
    checks++; if ({bus.mem_addr, bus.mem_data, done, pass, err_count, first_err_addr} !== '0) begin errors++;
      $display("FAIL midwrite_outputs got addr=%0d data=%0h done=%b pass=%b err=%0d first=%0d want all 0",
               bus.mem_addr, bus.mem_data, done, pass, err_count, first_err_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin errors++;
      $display("FAIL midwrite_stays_idle got busy=%b we=%b want 0 0", busy, bus.mem_we); end
    $display("test_reset_mid_write done");
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_random_faults();
    test_single_fault();
    test_multi_fault();
    test_start_ignored();
    test_read_timing();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
